// File: rtl/regfile_write_arbiter.sv
// Round-robin owner of the register file write port, with a clear sequencer and a stall counter.
// Define REGFILE_R0_ZERO_EN to suppress requester writes to r0 (the clear sequence still writes it).
module regfile_write_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int STALL_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [ADDR_W-1:0]  a_reg,
  input  logic [DATA_W-1:0]  a_data,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [ADDR_W-1:0]  b_reg,
  input  logic [DATA_W-1:0]  b_data,
  input  logic               clr_start,
  output logic               clr_busy,
  output logic               rf_write,
  output logic [ADDR_W-1:0]  rf_write_reg,
  output logic [DATA_W-1:0]  rf_write_data,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic {ARB, CLEAR} state_t;

  localparam logic [ADDR_W-1:0]  LAST_REG  = ADDR_W'(NUM_REGS - 1);
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  state_t             state_reg;
  logic [ADDR_W-1:0]  clr_cnt_reg;
  logic               ptr_b_reg;   // 1 = B wins the next contested cycle
  logic               grant_a;
  logic               grant_b;
  logic               contested;
  logic               stalled;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_reg;
  logic [DATA_W-1:0]  wr_data;

  // Grants are withheld while reset is asserted so no request is consumed and then dropped.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst && state_reg == ARB && !clr_start) begin
      grant_a = a_valid && (!b_valid || !ptr_b_reg);
      grant_b = b_valid && (!a_valid || ptr_b_reg);
    end
  end

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign contested = a_valid && b_valid;
  assign stalled   = (a_valid && !grant_a) || (b_valid && !grant_b);
  assign wr_reg    = grant_a ? a_reg : b_reg;
  assign wr_data   = grant_a ? a_data : b_data;
  assign clr_busy  = (state_reg == CLEAR);

`ifdef REGFILE_R0_ZERO_EN
  assign wr_en = (grant_a || grant_b) && (wr_reg != '0);
`else
  assign wr_en = grant_a || grant_b;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= ARB;
      clr_cnt_reg   <= '0;
      ptr_b_reg     <= 1'b0;
      rf_write      <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      stall_cnt     <= '0;
    end else begin
      if (stalled && stall_cnt != STALL_MAX)
        stall_cnt <= stall_cnt + 1'b1;
      rf_write <= 1'b0;
      case (state_reg)
        ARB: begin
          if (clr_start) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
          end else begin
            if (wr_en) begin
              rf_write      <= 1'b1;
              rf_write_reg  <= wr_reg;
              rf_write_data <= wr_data;
            end
            // A contested grant hands priority to the loser.
            if (contested && (grant_a || grant_b))
              ptr_b_reg <= grant_a;
          end
        end
        CLEAR: begin
          rf_write      <= 1'b1;
          rf_write_reg  <= clr_cnt_reg;
          rf_write_data <= '0;
          clr_cnt_reg   <= clr_cnt_reg + 1'b1;
          if (clr_cnt_reg == LAST_REG)
            state_reg <= ARB;
        end
        default: state_reg <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter, checked every cycle against a transaction-level model.
module tb_regfile_write_arbiter;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              a_valid = 1'b0, b_valid = 1'b0, clr_start = 1'b0;
  logic [ADDR_W-1:0] a_reg = '0, b_reg = '0;
  logic [DATA_W-1:0] a_data = '0, b_data = '0;

  logic              a_ready, b_ready, clr_busy, rf_write;
  logic [ADDR_W-1:0] rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  logic [15:0]       stall_cnt;

  logic              a_ready4, b_ready4, clr_busy4, rf_write4;
  logic [ADDR_W-1:0] rf_write_reg4;
  logic [DATA_W-1:0] rf_write_data4;
  logic [3:0]        stall_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .STALL_W(16)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .rf_write(rf_write), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .stall_cnt(stall_cnt)
  );

  // Narrow-counter instance shares every input to exercise saturation.
  regfile_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .STALL_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready4), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready4), .b_reg(b_reg), .b_data(b_data),
    .clr_start(clr_start), .clr_busy(clr_busy4),
    .rf_write(rf_write4), .rf_write_reg(rf_write_reg4), .rf_write_data(rf_write_data4),
    .stall_cnt(stall_cnt4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: whose turn it is, how many clear writes remain, the last write seen.
  bit          m_known = 0;
  bit          m_pref_b;
  bit          m_in_clear;
  int          m_clear_idx;
  bit          m_wr;
  int unsigned m_wr_reg;
  int unsigned m_wr_data;
  int          m_stalls;

  always @(negedge clk) begin
    bit ea, eb;
    int e16, e4;
    ea  = rst && !m_in_clear && !clr_start && a_valid && (!b_valid || !m_pref_b);
    eb  = rst && !m_in_clear && !clr_start && b_valid && (!a_valid || m_pref_b);
    e16 = (m_stalls > 65535) ? 65535 : m_stalls;
    e4  = (m_stalls > 15) ? 15 : m_stalls;
    if (m_known) begin
      if (rst) begin
        check("a_ready", 64'(a_ready), 64'(ea));
        check("b_ready", 64'(b_ready), 64'(eb));
        check("a_ready4", 64'(a_ready4), 64'(ea));
        check("b_ready4", 64'(b_ready4), 64'(eb));
      end
      check("rf_write", 64'(rf_write), 64'(m_wr));
      check("rf_write_reg", 64'(rf_write_reg), 64'(m_wr_reg));
      check("rf_write_data", 64'(rf_write_data), 64'(m_wr_data));
      check("clr_busy", 64'(clr_busy), 64'(m_in_clear));
      check("stall_cnt", 64'(stall_cnt), 64'(e16));
      check("rf_write4", 64'(rf_write4), 64'(m_wr));
      check("rf_write_reg4", 64'(rf_write_reg4), 64'(m_wr_reg));
      check("rf_write_data4", 64'(rf_write_data4), 64'(m_wr_data));
      check("clr_busy4", 64'(clr_busy4), 64'(m_in_clear));
      check("stall_cnt4", 64'(stall_cnt4), 64'(e4));
    end
    // Advance the model to what the next rising edge must produce.
    if (!rst) begin
      m_known = 1; m_pref_b = 0; m_in_clear = 0; m_clear_idx = 0;
      m_wr = 0; m_wr_reg = 0; m_wr_data = 0; m_stalls = 0;
    end else if (m_known) begin
      if ((a_valid && !ea) || (b_valid && !eb)) m_stalls++;
      m_wr = 0;
      if (m_in_clear) begin
        m_wr = 1; m_wr_reg = m_clear_idx; m_wr_data = 0;
        m_clear_idx++;
        if (m_clear_idx == NUM_REGS) m_in_clear = 0;
      end else if (clr_start) begin
        m_in_clear = 1; m_clear_idx = 0;
      end else if (ea || eb) begin
        int unsigned r, d;
        r = ea ? a_reg : b_reg;
        d = ea ? a_data : b_data;
`ifdef REGFILE_R0_ZERO_EN
        if (r != 0) begin m_wr = 1; m_wr_reg = r; m_wr_data = d; end
`else
        m_wr = 1; m_wr_reg = r; m_wr_data = d;
`endif
        if (a_valid && b_valid) m_pref_b = ea;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_valid = 0; b_valid = 0; clr_start = 0; rst = 0;
    step(); step();
    rst = 1;
  endtask

  initial begin
    // Write from A alone
    do_reset();
    @(negedge clk);
    check("reset_rf_write", 64'(rf_write), 64'd0);
    check("reset_rf_write_reg", 64'(rf_write_reg), 64'd0);
    check("reset_stall_cnt", 64'(stall_cnt), 64'd0);
    check("reset_clr_busy", 64'(clr_busy), 64'd0);
    a_valid = 1; a_reg = 5; a_data = 32'hDEADBEEF;
    @(negedge clk);
    check("t1_a_ready", 64'(a_ready), 64'd1);
    step(); a_valid = 0;
    @(negedge clk);
    check("t1_wr", 64'(rf_write), 64'd1);
    check("t1_reg", 64'(rf_write_reg), 64'd5);
    check("t1_data", 64'(rf_write_data), 64'hDEADBEEF);
    step();
    @(negedge clk);
    check("t1_idle", 64'(rf_write), 64'd0);
    $display("txn: single A write reg 5 done");

    // Contested round-robin
    do_reset();
    a_valid = 1; a_reg = 3; a_data = 32'h11;
    b_valid = 1; b_reg = 4; b_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_a_ready", 64'(a_ready), 64'((i % 2) == 0));
      check("t2_b_ready", 64'(b_ready), 64'((i % 2) == 1));
      if (i > 0) check("t2_reg_seq", 64'(rf_write_reg), (i % 2) == 1 ? 64'd3 : 64'd4);
      step();
    end
    a_valid = 0; b_valid = 0;
    @(negedge clk);
    check("t2_last_reg", 64'(rf_write_reg), 64'd4);
    check("t2_last_data", 64'(rf_write_data), 64'h22);
    check("t2_stall", 64'(stall_cnt), 64'd4);
    $display("txn: contested A/B x4 done");

    // Clear with a waiting request
    do_reset();
    clr_start = 1; a_valid = 1; a_reg = 7; a_data = 32'h55;
    @(negedge clk);
    check("t3_a_ready_start", 64'(a_ready), 64'd0);
    step(); clr_start = 0;
    for (int k = 0; k < NUM_REGS; k++) begin
      @(negedge clk);
      check("t3_a_ready_clear", 64'(a_ready), 64'd0);
      check("t3_busy", 64'(clr_busy), 64'd1);
      if (k > 0) begin
        check("t3_wr", 64'(rf_write), 64'd1);
        check("t3_reg", 64'(rf_write_reg), 64'(k - 1));
        check("t3_data", 64'(rf_write_data), 64'd0);
      end
      step();
    end
    @(negedge clk);
    check("t3_last_reg", 64'(rf_write_reg), 64'd31);
    check("t3_busy_end", 64'(clr_busy), 64'd0);
    check("t3_a_ready_after", 64'(a_ready), 64'd1);
    step(); a_valid = 0;
    @(negedge clk);
    check("t3_a_wr", 64'(rf_write), 64'd1);
    check("t3_a_reg", 64'(rf_write_reg), 64'd7);
    check("t3_a_data", 64'(rf_write_data), 64'h55);
    $display("txn: clear with waiting A done");

    // Reset mid-clear
    do_reset();
    clr_start = 1;
    step(); clr_start = 0;
    repeat (10) step();
    @(negedge clk);
    check("t4_pre_reg", 64'(rf_write_reg), 64'd9);
    rst = 0;
    step();
    rst = 1; b_valid = 1; b_reg = 9; b_data = 32'h99;
    @(negedge clk);
    check("t4_wr", 64'(rf_write), 64'd0);
    check("t4_busy", 64'(clr_busy), 64'd0);
    check("t4_stall", 64'(stall_cnt), 64'd0);
    check("t4_b_ready", 64'(b_ready), 64'd1);
    step(); b_valid = 0;
    @(negedge clk);
    check("t4_b_wr", 64'(rf_write), 64'd1);
    check("t4_b_reg", 64'(rf_write_reg), 64'd9);
    $display("txn: reset mid-clear then B write done");

    // Stall saturation
    do_reset();
    a_valid = 1; a_reg = 1; a_data = 32'hA1;
    b_valid = 1; b_reg = 2; b_data = 32'hB2;
    repeat (20) step();
    a_valid = 0; b_valid = 0;
    @(negedge clk);
    check("t5_stall4", 64'(stall_cnt4), 64'd15);
    check("t5_stall16", 64'(stall_cnt), 64'd20);
    $display("txn: stall saturation done");

    // r0 write
    do_reset();
    a_valid = 1; a_reg = 0; a_data = 32'hFFFFFFFF;
    @(negedge clk);
    check("t6_a_ready", 64'(a_ready), 64'd1);
    step(); a_valid = 0;
    @(negedge clk);
`ifdef REGFILE_R0_ZERO_EN
    check("t6_wr", 64'(rf_write), 64'd0);
`else
    check("t6_wr", 64'(rf_write), 64'd1);
    check("t6_reg", 64'(rf_write_reg), 64'd0);
    check("t6_data", 64'(rf_write_data), 64'hFFFFFFFF);
`endif
    $display("txn: r0 write done");

    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Sole owner of the register file's single write port (write, write_reg, write_data).
- Shares that port between two writeback requesters: A (ALU writeback) and B (load/memory writeback), using round-robin arbitration with valid/ready handshakes.
- Contains a clear sequencer that zeroes all registers on command.
- Keeps a saturating stall counter for performance debug.

Parameters:
- ADDR_W, 5, register index width.
- DATA_W, 32, register data width.
- NUM_REGS, 32, registers walked by the clear sequencer (must be at most 2**ADDR_W).
- STALL_W, 16, stall counter width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset).
- a_valid  input  1  requester A has a write pending.
- a_ready  output  1  A's write accepted this cycle.
- a_reg  input  ADDR_W  A's destination index.
- a_data  input  DATA_W  A's write data.
- b_valid  input  1  requester B has a write pending.
- b_ready  output  1  B's write accepted this cycle.
- b_reg  input  ADDR_W  B's destination index.
- b_data  input  DATA_W  B's write data.
- clr_start  input  1  single-cycle pulse that starts the clear sequence.
- clr_busy  output  1  clear sequence in progress.
- rf_write  output  1  to the register file's write input.
- rf_write_reg  output  ADDR_W  to the register file's write_reg.
- rf_write_data  output  DATA_W  to the register file's write_data.
- stall_cnt  output  STALL_W  saturating count of stalled request-cycles.

Behaviour:
- Reset (rst=0 at posedge):
  - state=ARB, clear counter=0, priority pointer=A.
  - rf_write=0, rf_write_reg=0, rf_write_data=0, clr_busy=0, stall_cnt=0.
  - Reset overrides every state, including mid-clear. In-flight requests are dropped; requesters must re-present them.
- States:
  - ARB: normal arbitration.
  - CLEAR: walks registers 0..NUM_REGS-1.
- ARB, readiness (combinational from state, valids and pointer):
  - a_ready=1 when a_valid and (!b_valid or pointer==A).
  - b_ready=1 when b_valid and (!a_valid or pointer==B).
  - Both readies are 0 in any cycle where clr_start=1 or state=CLEAR.
  - At most one ready is high per cycle.
- Handshake:
  - Transfer occurs when valid and ready are both high.
  - A requester must hold valid/reg/data stable until accepted.
  - valid must not depend on ready.
- Latency and throughput:
  - Transfer in cycle N gives registered rf_write=1, rf_write_reg=reg, rf_write_data=data in cycle N+1.
  - In a cycle with no transfer, rf_write=0; rf_write_reg/rf_write_data hold their previous values.
  - Throughput is one write per cycle.
- Priority pointer:
  - Updates only on a contested grant (both valid): it moves to the loser.
  - An uncontested grant leaves the pointer unchanged.
- Same destination index from A and B: both writes still occur, in grant order. The later write wins in the register file.
- stall_cnt:
  - +1 per cycle where (a_valid and !a_ready) or (b_valid and !b_ready); counts the cycle once even if both requesters are stalled.
  - Saturates at all-ones and clears only on reset.
- Clear sequence:
  - clr_start=1 in ARB moves to CLEAR at the next edge with counter=0. This start takes priority over any requests that cycle.
  - In CLEAR, each cycle registers rf_write=1, rf_write_reg=counter, rf_write_data=0, then counter+1.
  - When the NUM_REGS-1 write is issued, return to ARB.
  - The write outputs therefore show regs 0..NUM_REGS-1 on NUM_REGS consecutive cycles, starting one cycle after entering CLEAR.
  - clr_busy=1 from the CLEAR entry cycle through the cycle in which the last clear write is issued (NUM_REGS cycles).
  - clr_start while in CLEAR is ignored.

Optional Feature:
- Macro: REGFILE_R0_ZERO_EN.
- Defined: an accepted write with reg==0 completes its handshake normally but produces rf_write=0 in cycle N+1, so r0 stays zero. The clear sequence still writes r0. Stall counting and the priority pointer are unaffected.
- Undefined: r0 is written like any other register.

Test Plan:
- Write from A alone: release reset; a_valid=1, a_reg=5, a_data=0xDEADBEEF -> a_ready=1 in the same cycle; next cycle rf_write=1, rf_write_reg=5, rf_write_data=0xDEADBEEF; the following cycle rf_write=0.
- Contested round-robin: A (reg 3, 0x11) and B (reg 4, 0x22), each re-asserted immediately after every acceptance, for 4 cycles -> grants A,B,A,B; rf_write_reg sequence 3,4,3,4 at 1-cycle latency; stall_cnt=4.
- Clear with a waiting request: clr_start pulse with a_valid=1 (reg 7, 0x55) -> a_ready=0 for 33 cycles; rf_write=1 with regs 0..31 and data 0 on 32 consecutive cycles; clr_busy high 32 cycles; then A is accepted and reg 7 is written with 0x55.
- Reset mid-clear: rst=0 when counter=10 -> next cycle rf_write=0, clr_busy=0, stall_cnt=0, state ARB; after rst=1, a B request is accepted in the same cycle.
- Stall saturation: force STALL_W=4, hold A and B valid for 20 cycles -> stall_cnt stops at 15.
- r0 write: A writes reg 0 with 0xFFFFFFFF -> with REGFILE_R0_ZERO_EN, a_ready=1 and rf_write stays 0; without it, rf_write=1, rf_write_reg=0, rf_write_data=0xFFFFFFFF.
